// File: rtl/fact_pkg.sv
// Shared definitions for the forward and inverse factorial blocks:
// default widths, the largest recoverable argument and the FSM encoding.
package fact_pkg;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_VAL_WIDTH = DEFAULT_WIDTH * 11;
    localparam int N_MAX             = (1 << DEFAULT_WIDTH) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : fact_pkg

// File: rtl/fact_inverse_seq.sv
// Sequential inverse factorial: finds the largest n with n! <= value.
// It builds the running product 1!, 2!, ... with one multiply per cycle.
// It stops at the first product that would overshoot, or when n reaches
// its maximum. It also reports whether the value was exactly n!.
module fact_inverse_seq
    import fact_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int VAL_WIDTH = WIDTH * 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VAL_WIDTH-1:0] value,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     n_out,
    output logic                 exact
);

    // The product is widened by WIDTH bits so prod*(idx+1) can never wrap.
    localparam int PW = VAL_WIDTH + WIDTH;
    localparam logic [WIDTH-1:0] IDX_LAST = '1;

    state_t               state;
    state_t               state_next;
    logic [VAL_WIDTH-1:0] val_q;
    logic [VAL_WIDTH-1:0] prod;
    logic [WIDTH-1:0]     idx;
    logic [WIDTH-1:0]     idx_inc;
    logic [PW-1:0]        nxt;
    logic                 accept;
    logic                 finish;
    logic                 advance;

    assign idx_inc = idx + WIDTH'(1);
    assign nxt     = PW'(prod) * PW'(idx_inc);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept start in IDLE, decide exit or advance in RUN
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((nxt > PW'(val_q)) || (idx == IDX_LAST)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers; done is a one-cycle registered pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            prod  <= VAL_WIDTH'(1);
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            n_out <= '0;
            exact <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                val_q <= value;
                prod  <= VAL_WIDTH'(1);
                idx   <= '0;
                busy  <= 1'b1;
            end
            if (finish) begin
                n_out <= idx;
                exact <= (prod == val_q);
                done  <= 1'b1;
                busy  <= 1'b0;
            end
            if (advance) begin
                prod <= nxt[VAL_WIDTH-1:0];
                idx  <= idx_inc;
            end
        end
    end

endmodule : fact_inverse_seq

// File: tb/tb_fact_inverse_seq.sv
// Self-checking bench for fact_inverse_seq. A plain factorial table serves
// as the reference model. Directed boundary cases are followed by
// randomized values clustered around factorial boundaries.
module tb_fact_inverse_seq;

    localparam int WIDTH     = 4;
    localparam int VAL_WIDTH = 44;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [VAL_WIDTH-1:0] value;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     n_out;
    logic                 exact;

    int checks;
    int errors;

    fact_inverse_seq #(.WIDTH(WIDTH), .VAL_WIDTH(VAL_WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .n_out (n_out),
        .exact (exact)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Forward factorial, used as the reference
    function automatic longint fact(input int n);
        longint f = 1;
        for (int k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    // Largest n in 0..15 with n! <= v, and whether v equals that n!
    function automatic void refModel(input logic [VAL_WIDTH-1:0] v, output int n, output bit ex);
        longint lv = longint'(v);
        n = 0;
        for (int k = 1; k <= 15; k++) begin
            if (fact(k) <= lv) n = k;
        end
        ex = (fact(n) == lv);
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for done; the caller has just sampled #1 after an edge
    task automatic waitDone(input int c0, output int lat, output int busy_cnt);
        int c = c0;
        busy_cnt = busy ? 1 : 0;
        while (!done && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (busy && !done) busy_cnt++;
        end
        if (!done) checkOutput("done_timeout", 0, 1);
        lat = c;
    endtask

    // Pulses start for one edge with value v, then waits for the result
    task automatic applyStimulus(input logic [VAL_WIDTH-1:0] v, output int lat, output int busy_cnt);
        start = 1'b1;
        value = v;
        @(posedge clk); #1;
        start = 1'b0;
        value = $urandom;
        waitDone(0, lat, busy_cnt);
    endtask

    // Full search with result, latency, busy-length and done-pulse checks
    task automatic runCase(input string tag, input logic [VAL_WIDTH-1:0] v);
        int lat, bc, n_exp;
        bit ex_exp;
        refModel(v, n_exp, ex_exp);
        applyStimulus(v, lat, bc);
        checkOutput({tag, "_n"}, n_out, n_exp);
        checkOutput({tag, "_exact"}, exact, ex_exp);
        checkOutput({tag, "_latency"}, lat, n_exp + 1);
        checkOutput({tag, "_busy_cycles"}, bc, n_exp + 1);
        checkOutput({tag, "_busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int lat, bc, n_exp;
        bit ex_exp, saw_done;
        logic [VAL_WIDTH-1:0] v;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        value  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_n", n_out, 0);
        checkOutput("rst_exact", exact, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        runCase("v120", 44'd120);
        runCase("v121", 44'd121);
        runCase("v719", 44'd719);
        runCase("v720", 44'd720);
        runCase("v0", 44'd0);
        runCase("v1", 44'd1);
        runCase("v15f", 44'd1307674368000);
        runCase("vmax", {VAL_WIDTH{1'b1}});

        // Start during busy is ignored; start in the done cycle is accepted
        start = 1'b1;
        value = 44'd24;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        value = 44'd5040;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(3, lat, bc);
        checkOutput("ignore_n", n_out, 4);
        checkOutput("ignore_exact", exact, 1);
        checkOutput("ignore_latency", lat, 5);
        start = 1'b1;
        value = 44'd5040;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("done_cycle_start_busy", busy, 1);
        waitDone(0, lat, bc);
        checkOutput("done_cycle_n", n_out, 7);
        checkOutput("done_cycle_exact", exact, 1);
        checkOutput("done_cycle_latency", lat, 8);
        @(posedge clk); #1;

        // Reset in the middle of a search
        start = 1'b1;
        value = 44'd720;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_n", n_out, 0);
        checkOutput("midrst_exact", exact, 0);
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("midrst_no_done", saw_done, 0);

        // Randomized values, mostly near factorial boundaries
        for (int i = 0; i < 30; i++) begin
            int k;
            longint off;
            k = $urandom_range(0, 15);
            off = longint'($urandom_range(0, 4)) - 2;
            if ($urandom_range(0, 3) == 0)
                v = {$urandom, $urandom} & {VAL_WIDTH{1'b1}};
            else if (fact(k) + off < 0)
                v = '0;
            else
                v = VAL_WIDTH'(fact(k) + off);
            refModel(v, n_exp, ex_exp);
            applyStimulus(v, lat, bc);
            checkOutput("rand_n", n_out, n_exp);
            checkOutput("rand_exact", exact, ex_exp);
            checkOutput("rand_latency", lat, n_exp + 1);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fact_inverse_seq

// File: doc/fact_inverse_seq.md
Name: fact_inverse_seq

Overview:
- Sequential inverse of the combinational factorial block.
- Given a VAL_WIDTH-bit value, finds the largest n (0..2^WIDTH-1) with n! <= value.
- Flags whether value is exactly n!.
- Computes one multiply per cycle under a start/busy/done handshake. Used wherever factorial results must be decoded back to their argument.

Parameters:
- WIDTH, 4, bit width of the recovered argument n; max n = 2^WIDTH-1.
- VAL_WIDTH, WIDTH*11 (44), bit width of the input value; matches the forward factorial output width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- value  input  VAL_WIDTH  operand; captured on the accepted start edge
- busy  output  1  high while a search is in progress
- done  output  1  one-cycle pulse when n_out/exact are valid
- n_out  output  WIDTH  largest n with n! <= value
- exact  output  1  1 iff n_out! == value

Behaviour:
- Reset values (rst high at a clk edge, from any state, including mid-search):
  - state=IDLE; busy=0, done=0, n_out=0, exact=0.
  - Internal prod=1, idx=0, captured value=0.
- FSM states: IDLE, RUN. done is a registered pulse, not a state.
- IDLE:
  - On an edge with start=1: capture value into val_q; prod<=1; idx<=0; state<=RUN; busy<=1.
  - start=0: hold state. n_out and exact keep their last result.
- RUN, each edge:
  - Compute nxt = prod*(idx+1) in VAL_WIDTH+WIDTH bits, so the product never wraps.
  - If nxt > val_q or idx == 2^WIDTH-1 (exit):
    - n_out<=idx; exact<=(prod==val_q); done<=1.
    - busy<=0; state<=IDLE.
  - Otherwise (advance): prod<=nxt[VAL_WIDTH-1:0]; idx<=idx+1.
- done is high for exactly one cycle, the cycle after the exit edge. It is deasserted on the next edge.
- Latency: the accepted start edge is edge 0. done and results are visible after edge n_out+1. Maximum is 2^WIDTH cycles (16 at default).
- start while busy=1 is ignored; value changes during RUN are ignored.
- start asserted in the same cycle done is high is accepted, because state is already IDLE. New results overwrite on the next exit.
- Boundary cases:
  - value=0: exits on edge 1 with n_out=0, exact=0.
  - value=1: 0!=1!=1, and the block reports the larger, so n_out=1, exact=1.
  - Saturation: when value >= 15! (at default width), n_out=15. exact=1 only when value==15!.
  - 15! = 1307674368000 fits in 44 bits; prod never exceeds VAL_WIDTH bits.
- rst takes priority over start in the same cycle.

Decomposition:
- Shared package fact_pkg holds:
  - FSM state encoding (IDLE, RUN).
  - N_MAX = 2^WIDTH-1.
  - Default WIDTH and VAL_WIDTH = WIDTH*11, shared with the forward factorial block.
- No sub-module; the single multiply-compare datapath stays inline.
- The forward factorial block serves as the reference model in the bench.

Test Plan:
- value=120, start pulse -> done after 6 cycles; n_out=5, exact=1; busy high for 6 cycles.
- value=121, then value=719 -> n_out=5, exact=0 both times. value=720 -> n_out=6, exact=1, done after 7 cycles.
- value=0 -> done after 1 cycle; n_out=0, exact=0. value=1 -> done after 2 cycles; n_out=1, exact=1.
- Saturation:
  - value=1307674368000 (15!) -> n_out=15, exact=1, done after 16 cycles.
  - value=2^44-1 -> n_out=15, exact=0.
- start with value=24; re-pulse start with value=5040 at cycle 2 -> second start ignored; n_out=4, exact=1. Then start in the done cycle with value=5040 -> accepted; n_out=7, exact=1.
- rst asserted at cycle 3 of a value=720 search -> next cycle busy=0, done=0, n_out=0, exact=0. No done pulse until a new start.
